// File: rtl/fb_dma_pkg.sv
// fb_dma_pkg: register map, CTRL/status bit positions and FSM encoding shared by the DMA block.
// Revision 1.0
`default_nettype none

package fb_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write fields
  localparam int CTRL_START     = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_ABORT     = 2;
  localparam int CTRL_CLR_DONE  = 3;

  // CTRL read fields
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_IRQ_EN    = 2;
  localparam int STAT_ABORTED   = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] RWAIT = 2'd2;
  localparam logic [1:0] WR    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fb_dma_regs.sv
// fb_dma_regs: SRC/DST/LEN/irq_en registers, CTRL write decode and register readback mux.
// Revision 1.0
`default_nettype none

module fb_dma_regs
  import fb_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_sel,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_din,
  output logic [31:0]       cfg_dout,
  input  logic              busy,
  input  logic              done,
  input  logic              aborted,
  input  logic [LEN_W-1:0]  remaining,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic              irq_en,
  output logic              ctrl_wr,
  output logic [3:0]        ctrl_bits
);

  logic wr_hit;

  assign wr_hit    = cfg_sel & cfg_we;
  assign ctrl_wr   = wr_hit & (cfg_addr[3:2] == REG_CTRL);
  assign ctrl_bits = cfg_din[3:0];

  // Transfer parameters are frozen while a copy is in flight; irq_en is not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      irq_en <= 1'b0;
    end else if (wr_hit) begin
      case (cfg_addr[3:2])
        REG_SRC:  if (!busy) src <= {cfg_din[ADDR_W-1:2], 2'b00};
        REG_DST:  if (!busy) dst <= {cfg_din[ADDR_W-1:2], 2'b00};
        REG_LEN:  if (!busy) len <= cfg_din[LEN_W-1:0];
        default:  irq_en <= cfg_din[CTRL_IRQ_EN];
      endcase
    end
  end

  always_comb begin
    cfg_dout = '0;
    case (cfg_addr[3:2])
      REG_SRC:  cfg_dout = 32'(src);
      REG_DST:  cfg_dout = 32'(dst);
      REG_LEN:  cfg_dout = 32'(len);
      default: begin
        cfg_dout[31:16]        = 16'(remaining);
        cfg_dout[STAT_BUSY]    = busy;
        cfg_dout[STAT_DONE]    = done;
        cfg_dout[STAT_IRQ_EN]  = irq_en;
        cfg_dout[STAT_ABORTED] = aborted;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fb_dma_ctrl.sv
// fb_dma_ctrl: word-copy DMA into framebuffer/char memory, yielding the shared bus to the CPU.
// Revision 1.0
`default_nettype none

module fb_dma_ctrl
  import fb_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_sel,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_din,
  output logic [31:0]       cfg_dout,
  input  logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              irq
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       latch;
  logic              done, aborted, busy;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  len;
  logic              irq_en, ctrl_wr;
  logic [3:0]        ctrl_bits;
  logic              start_go, abort_go, clr_go;
  logic              unused_cfg_re;

  // Reads are side-effect free, so the read strobe carries no information here.
  assign unused_cfg_re = cfg_re;

  assign busy     = (state != IDLE);
  assign start_go = ctrl_wr & ctrl_bits[CTRL_START] & ~ctrl_bits[CTRL_ABORT] & ~busy;
  assign abort_go = ctrl_wr & ctrl_bits[CTRL_ABORT] & busy;
  assign clr_go   = ctrl_wr & ctrl_bits[CTRL_CLR_DONE];
  assign irq      = done & irq_en;

  fb_dma_regs #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_regs (
    .clock     (clock),
    .reset     (reset),
    .cfg_sel   (cfg_sel),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_din   (cfg_din),
    .cfg_dout  (cfg_dout),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .remaining (remaining),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .irq_en    (irq_en),
    .ctrl_wr   (ctrl_wr),
    .ctrl_bits (ctrl_bits)
  );

  // Bus drive is purely combinational so an async reset releases it at once;
  // the abort cycle is masked so no partial word reaches memory.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!cpu_busy && !abort_go) begin
      case (state)
        RD: begin
          mem_req  = 1'b1;
          mem_addr = cur_src;
        end
        WR: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = cur_dst;
          mem_wdata = latch;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      latch     <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      if (clr_go) done <= 1'b0;
      if (abort_go) begin
        state   <= IDLE;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start_go) begin
            cur_src   <= src;
            cur_dst   <= dst;
            remaining <= len;
            aborted   <= 1'b0;
            done      <= (len == '0);
            state     <= (len == '0) ? IDLE : RD;
          end
          RD: if (!cpu_busy) state <= RWAIT;
          RWAIT: begin
            latch <= mem_rdata;
            state <= WR;
          end
          default: if (!cpu_busy) begin
            cur_src   <= cur_src + ADDR_W'(4);
            cur_dst   <= cur_dst + ADDR_W'(4);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= RD;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_dma_ctrl.sv
// tb_fb_dma_ctrl: table-driven, randomized and hand-sequenced checks of fb_dma_ctrl.
// Revision 1.0
`default_nettype none

module tb_fb_dma_ctrl;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int BOUND  = 4000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_sel, cfg_we, cfg_re;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_din, cfg_dout;
  logic        cpu_busy;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        irq;

  always #5 clock = ~clock;

  fb_dma_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_sel   (cfg_sel),
    .cfg_we    (cfg_we),
    .cfg_re    (cfg_re),
    .cfg_addr  (cfg_addr),
    .cfg_din   (cfg_din),
    .cfg_dout  (cfg_dout),
    .cpu_busy  (cpu_busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .irq       (irq)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Source memory contents: a fixed function of the byte address.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[31:16]} + 32'h0102_0304;
  endfunction

  // Bus monitor and one-cycle-latency read responder.
  logic [31:0] rd_q[$];
  logic [31:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];
  int          overlap = 0;

  always begin
    logic        rd_now;
    logic [31:0] a;
    @(negedge clock);
    #4;
    rd_now = mem_req && !mem_we;
    a      = mem_addr;
    if (mem_req && cpu_busy) overlap++;
    if (rd_now) rd_q.push_back(mem_addr);
    if (mem_req && mem_we) begin
      wr_a_q.push_back(mem_addr);
      wr_d_q.push_back(mem_wdata);
    end
    @(posedge clock);
    #1;
    mem_rdata = rd_now ? memval(a) : $urandom;
  end

  bit busy_arr [0:4095];

  // Expected completion: each word needs a free bus cycle for the read, one
  // turnaround cycle, then a free bus cycle for the write.
  function automatic int model_cycles(input int len);
    int t = 1;
    for (int w = 0; w < len; w++) begin
      while (busy_arr[t] && t < 4090) t++;
      t += 2;
      while (busy_arr[t] && t < 4090) t++;
      t++;
    end
    return t - 1;
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    cfg_sel  = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_din  = d;
    @(posedge clock);
    #1;
    cfg_sel = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfg_sel  = 1'b1;
    cfg_re   = 1'b1;
    cfg_addr = a;
    #1;
    d      = cfg_dout;
    cfg_sel = 1'b0;
    cfg_re  = 1'b0;
  endtask

  task automatic run(input string nm, input logic [31:0] src, input logic [31:0] dst,
                     input int len, input logic ien, input int exp);
    logic [31:0] st;
    logic [31:0] s0, d0;
    int n;
    s0 = src & 32'hFFFF_FFFC;
    d0 = dst & 32'hFFFF_FFFC;
    cfg_write(4'h0, src);
    cfg_write(4'h4, dst);
    cfg_write(4'h8, len);
    rd_q.delete();
    wr_a_q.delete();
    wr_d_q.delete();
    overlap = 0;
    cfg_write(4'hC, {30'd0, ien, 1'b1});
    n = 0;
    cfg_read(4'hC, st);
    while (!st[1] && n < BOUND) begin
      @(negedge clock);
      cpu_busy = busy_arr[n+1];
      @(posedge clock);
      #1;
      n++;
      cfg_read(4'hC, st);
    end
    @(negedge clock);
    cpu_busy = 1'b0;
    check({nm, " cycles"}, n, exp);
    check({nm, " status"}, st, {29'd0, ien, 2'b10});
    check({nm, " irq"}, {31'd0, irq}, {31'd0, ien});
    check({nm, " overlap"}, overlap, 0);
    check({nm, " nreads"}, rd_q.size(), len);
    check({nm, " nwrites"}, wr_a_q.size(), len);
    for (int i = 0; i < len && i < rd_q.size() && i < wr_a_q.size(); i++) begin
      check($sformatf("%s rd_addr[%0d]", nm, i), rd_q[i], s0 + 32'(4 * i));
      check($sformatf("%s wr_addr[%0d]", nm, i), wr_a_q[i], d0 + 32'(4 * i));
      check($sformatf("%s wr_data[%0d]", nm, i), wr_d_q[i], memval(s0 + 32'(4 * i)));
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic [31:0] mask;
    logic        ien;
    int          exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    vecs[0] = '{32'h0000_0100, 32'h0000_2000, 3, 32'h0, 1'b0, 9};
    vecs[1] = '{32'h0000_0100, 32'h0000_2000, 3, 32'h0000_0106, 1'b1, 12};
    vecs[2] = '{32'h0000_0000, 32'h0000_3000, 0, 32'h0, 1'b1, 0};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_4000, 2, 32'h0, 1'b0, 6};
    vecs[4] = '{32'h0000_0203, 32'h0000_5001, 4, 32'h0000_0055, 1'b0, 13};

    reset = 1'b1; cpu_busy = 1'b0;
    cfg_sel = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 4'h0; cfg_din = 32'h0;
    #12;
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_read(4'(a * 4), r);
      check($sformatf("rst reg%0d", a), r, 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    // Table-driven transfers with fixed CPU-busy patterns.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4096; k++) busy_arr[k] = (k < 32) ? vecs[v].mask[k] : 1'b0;
      run($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].ien, vecs[v].exp);
    end
    check("wrap rd_addr", (rd_q.size() > 1) ? rd_q[1] : 32'hDEAD_BEEF, 32'h0000_0200 + 32'h4);
    cfg_read(4'h0, r);
    check("src align", r, 32'h0000_0200);
    cfg_read(4'h4, r);
    check("dst align", r, 32'h0000_5000);

    // Randomized transfers and CPU contention against the phase model.
    for (int t = 0; t < 6; t++) begin
      logic [31:0] s, d;
      int l;
      s = $urandom;
      d = $urandom;
      l = $urandom_range(1, 6);
      for (int k = 0; k < 4096; k++) busy_arr[k] = (k < 200) ? ($urandom_range(0, 2) == 0) : 1'b0;
      run($sformatf("rnd%0d", t), s, d, l, t[0], model_cycles(l));
    end
    for (int k = 0; k < 4096; k++) busy_arr[k] = 1'b0;

    // LEN=0 with interrupt, then clear_done and irq_en update.
    cfg_write(4'h8, 32'd0);
    cfg_write(4'hC, 32'h3);
    cfg_read(4'hC, r);
    check("len0 status", r, 32'h0000_0006);
    check("len0 irq", {31'd0, irq}, 32'd1);
    cfg_write(4'hC, 32'hA);
    cfg_read(4'hC, r);
    check("clr_done status", r, 32'h0000_0004);
    check("clr_done irq", {31'd0, irq}, 32'd0);
    cfg_write(4'hC, 32'h0);
    cfg_read(4'hC, r);
    check("irq_en off", r, 32'h0);

    // Abort after the second word's write.
    cfg_write(4'h0, 32'h0000_0800);
    cfg_write(4'h4, 32'h0000_9000);
    cfg_write(4'h8, 32'd8);
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    cfg_write(4'hC, 32'h1);
    repeat (3) @(posedge clock);
    cfg_write(4'h0, 32'h0000_1234);
    repeat (2) @(posedge clock);
    cfg_write(4'hC, 32'h5);
    cfg_read(4'hC, r);
    check("abort status", r, 32'h0006_0008);
    cfg_read(4'h0, r);
    check("busy src write ignored", r, 32'h0000_0800);
    repeat (10) @(posedge clock);
    #1;
    check("abort nreads", rd_q.size(), 2);
    check("abort nwrites", wr_a_q.size(), 2);
    check("abort irq", {31'd0, irq}, 32'd0);

    // Asynchronous reset while a write is on the bus.
    cfg_write(4'h0, 32'h0000_0100);
    cfg_write(4'h4, 32'h0000_2000);
    cfg_write(4'h8, 32'd3);
    cfg_write(4'hC, 32'h3);
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    repeat (2) @(posedge clock);
    #3;
    check("pre-reset in WR", {30'd0, mem_req, mem_we}, 32'd3);
    reset = 1'b1;
    #1;
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    cfg_read(4'hC, r);
    check("reset ctrl", r, 32'd0);
    cfg_read(4'h0, r);
    check("reset src", r, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset nwrites", wr_a_q.size(), 0);
    run("post_reset", 32'h0000_0100, 32'h0000_2000, 3, 1'b0, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fb_dma_ctrl.md
Name: fb_dma_ctrl

Overview:
Memory-mapped DMA controller that copies word blocks from the data memory to the VGA framebuffer or character memory without CPU involvement. It shares the single data-memory bus with the CPU, and the CPU always has priority. The DMA issues a bus access only in cycles where the CPU is not using the bus. Software programs source, destination and length through four MMIO registers, then polls the status or takes the done interrupt.

Parameters:
ADDR_W, 32, byte address width of source/destination and of the bus.
LEN_W, 16, width of the transfer length, in 32-bit words.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high; clears all state.
cfg_sel  in  1  MMU select for the DMA register window.
cfg_we  in  1  register write strobe (qualified by cfg_sel).
cfg_re  in  1  register read strobe (qualified by cfg_sel).
cfg_addr  in  4  byte offset in the window; bits [3:2] pick the register.
cfg_din  in  32  register write data.
cfg_dout  out  32  register read data, combinational from cfg_addr.
cpu_busy  in  1  CPU owns the bus this cycle (dmemwe|dmemre).
mem_req  out  1  DMA drives the shared bus this cycle; top-level mux selects the DMA when high.
mem_we  out  1  1 = write access, 0 = read access.
mem_addr  out  ADDR_W  word-aligned bus address.
mem_wdata  out  32  write data.
mem_rdata  in  32  read data, valid exactly one cycle after a read issue.
irq  out  1  done & irq_en, level-sensitive.

Behaviour:
- Register map:
  - 0x0 SRC.
  - 0x4 DST.
  - 0x8 LEN, low LEN_W bits.
  - 0xC CTRL.
- CTRL write bits: bit0 start, bit1 irq_en, bit2 abort, bit3 clear_done.
- CTRL read bits: bit0 busy, bit1 done, bit2 irq_en, bit3 aborted, [31:16] remaining words.
- Reset: every register, the FSM (IDLE), the data latch and the counters go to 0. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, irq=0, cfg_dout reads 0.
- SRC/DST writes clear bits [1:0] (word alignment). Writes to SRC/DST/LEN while busy are ignored.
- FSM states: IDLE, RD, RWAIT, WR.
  - IDLE: on CTRL write with start=1, latch cur_src=SRC, cur_dst=DST, remaining=LEN. Clear done and aborted. If LEN==0, set done and stay in IDLE; otherwise go to RD.
  - RD: if cpu_busy=0, drive mem_req=1, mem_we=0, mem_addr=cur_src, and go to RWAIT. If cpu_busy=1, hold with mem_req=0.
  - RWAIT: capture mem_rdata into the data latch unconditionally; no bus use. Go to WR.
  - WR: if cpu_busy=0, drive mem_req=1, mem_we=1, mem_addr=cur_dst, mem_wdata=latch. Then cur_src+=4, cur_dst+=4 (modulo 2^ADDR_W, wrap allowed), remaining-=1. If remaining becomes 0, set done and go to IDLE; otherwise go to RD. If cpu_busy=1, hold.
- mem_req, mem_we, mem_addr and mem_wdata are combinational from state and cpu_busy. mem_req is never 1 in a cycle where cpu_busy=1.
- Minimum throughput: 3 cycles per word. Each CPU-busy cycle during RD or WR adds exactly 1 cycle.
- Start while busy is ignored. Abort takes priority over start when both bits are written in the same CTRL write.
- Abort while busy: go to IDLE next edge, set aborted=1, done stays 0, remaining is frozen for readback. No write is issued in the abort cycle.
- done is sticky. It is cleared by clear_done or by a new start.
- irq_en is updated on every CTRL write, whether busy or not.
- Asynchronous reset mid-transfer: the bus is released immediately (mem_req=0 without waiting for a clock edge). No partial-word write follows.
- cfg_re has no side effects.

Decomposition:
- Shared package fb_dma_pkg holds:
  - register offsets: REG_SRC, REG_DST, REG_LEN, REG_CTRL;
  - CTRL bit indices;
  - state enum: IDLE, RD, RWAIT, WR.
- Sub-module fb_dma_regs holds the register file, CTRL decode and readback mux. The FSM and datapath stay in fb_dma_ctrl.

Test Plan:
1. SRC=0x100, DST=0x2000, LEN=3, start, cpu_busy=0 -> reads of 0x100, 0x104, 0x108 and writes of 0x2000, 0x2004, 0x2008 with the matching data. done=1 exactly 9 cycles after the start edge; busy=0.
2. Same transfer with cpu_busy=1 for 2 cycles during the first RD and 1 cycle during the second WR -> mem_req never overlaps cpu_busy; done is reached after 12 cycles; data is correct.
3. LEN=0, start -> no mem_req ever; CTRL reads done=1, busy=0 on the next cycle; irq=1 if irq_en=1.
4. LEN=8, abort after the 2nd word's write -> returns to IDLE; aborted=1, done=0, remaining=6; no further mem_req.
5. SRC=0xFFFFFFFC, LEN=2 -> second read address wraps to 0x00000000.
6. Assert reset while in WR -> mem_req drops immediately; all CTRL fields read 0; irq=0; a fresh start then runs normally.
